// File: rtl/lcd_pkg.sv
// Shared constants, types and address helpers for the HD44780-style bus responder.
package lcd_pkg;

    // Field positions inside instruction bytes
    localparam int unsigned ENTRY_S_BIT  = 0;
    localparam int unsigned ENTRY_ID_BIT = 1;
    localparam int unsigned SHIFT_RL_BIT = 2;
    localparam int unsigned SHIFT_SC_BIT = 3;
    localparam int unsigned FUNC_DL_BIT  = 4;

    localparam logic [6:0] DDRAM_LINE0_FIRST = 7'h00;
    localparam logic [6:0] DDRAM_LINE0_LAST  = 7'h27;
    localparam logic [6:0] DDRAM_LINE1_FIRST = 7'h40;
    localparam logic [6:0] DDRAM_LINE1_LAST  = 7'h67;
    localparam int unsigned DDRAM_DEPTH      = 80;
    localparam int unsigned LINE_LEN         = 40;
    localparam logic [7:0] BLANK_CHAR        = 8'h20;

    localparam logic [6:0] LINE_STARTS [4] = '{7'h00, 7'h40, 7'h14, 7'h54};

    typedef enum logic [1:0] {
        StIdle,
        StClear,
        StBusyWait
    } state_e;

    typedef enum logic {
        SpaceDdram,
        SpaceCgram
    } space_e;

    function automatic logic ddram_addr_valid(input logic [6:0] addr);
        return (addr <= DDRAM_LINE0_LAST) ||
               ((addr >= DDRAM_LINE1_FIRST) && (addr <= DDRAM_LINE1_LAST));
    endfunction

    // Line 1 is packed directly after the 40 cells of line 0
    function automatic logic [6:0] addr_to_index(input logic [6:0] addr);
        return addr[6] ? (7'(LINE_LEN) + {1'b0, addr[5:0]}) : {1'b0, addr[5:0]};
    endfunction

    function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc,
                                           input logic cgram);
        logic [6:0] nxt;
        if (cgram) begin
            nxt = inc ? {1'b0, ac[5:0] + 6'd1} : {1'b0, ac[5:0] - 6'd1};
        end else if (inc) begin
            if (ac == DDRAM_LINE0_LAST) begin
                nxt = DDRAM_LINE1_FIRST;
            end else if (ac == DDRAM_LINE1_LAST) begin
                nxt = DDRAM_LINE0_FIRST;
            end else begin
                nxt = ac + 7'd1;
            end
        end else begin
            if (ac == DDRAM_LINE0_FIRST) begin
                nxt = DDRAM_LINE1_LAST;
            end else if (ac == DDRAM_LINE1_FIRST) begin
                nxt = DDRAM_LINE0_LAST;
            end else begin
                nxt = ac - 7'd1;
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/lcd_ddram.sv
// 80x8 shadow DDRAM: one synchronous bus port and one registered readback port.
module lcd_ddram
    import lcd_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       bus_we_i,
    input  logic [6:0] bus_idx_i,
    input  logic [7:0] bus_wdata_i,
    output logic [7:0] bus_rdata_o,
    input  logic       rd_valid_i,
    input  logic [6:0] rd_idx_i,
    output logic [7:0] rd_char_o
);

    logic [7:0] mem [DDRAM_DEPTH];
    logic [7:0] bus_rdata_q;
    logic [7:0] rd_char_d;
    logic [7:0] rd_char_q;

    always_ff @(posedge clk_i) begin
        if (bus_we_i) begin
            mem[bus_idx_i] <= bus_wdata_i;
        end
        bus_rdata_q <= mem[bus_idx_i];
    end

    // Non-blocking update of mem gives read-before-write on a same-cycle collision
    always_comb begin
        rd_char_d = BLANK_CHAR;
        if (rd_valid_i) begin
            rd_char_d = mem[rd_idx_i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_char_q <= BLANK_CHAR;
        end else begin
            rd_char_q <= rd_char_d;
        end
    end

    assign bus_rdata_o = bus_rdata_q;
    assign rd_char_o   = rd_char_q;

endmodule

// File: rtl/lcd_bus_responder.sv
// Display-side responder for the 8-bit HD44780-style LCD bus with a shadow DDRAM.
// Optional 64x8 CGRAM is built when LCD_RESP_CGRAM_EN is defined.
module lcd_bus_responder
    import lcd_pkg::*;
#(
    parameter int unsigned BUSY_CYCLES      = 50,
    parameter int unsigned BUSY_LONG_CYCLES = 1600
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       LCD_RS,
    input  logic       LCD_RW,
    input  logic       LCD_E,
    input  logic [7:0] LCD_DATA_IN,
    output logic [7:0] LCD_DATA_OUT,
    output logic       LCD_DATA_OE,
    input  logic [6:0] RD_ADDR,
    output logic [7:0] RD_CHAR,
    output logic [2:0] DISP_CTRL,
    output logic       BUSY,
    output logic       ERR
);

    localparam logic [15:0] ShortLoad = 16'(BUSY_CYCLES - 1);
    localparam logic [15:0] LongLoad  = 16'(BUSY_LONG_CYCLES - 1);
    localparam logic [6:0]  FillLast  = 7'(DDRAM_DEPTH - 1);

    logic [1:0] e_sync_q, rs_sync_q, rw_sync_q;
    logic [7:0] data_sync1_q, data_sync2_q;
    logic       e_prev_q, rs_prev_q, rw_prev_q;
    logic [7:0] data_prev_q;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [6:0]  fill_q, fill_d;
    logic [6:0]  ac_q, ac_d;
    logic        id_q, id_d;
    space_e      space_q, space_d;
    logic [2:0]  disp_q, disp_d;
    logic        err_q, err_d;
    logic [7:0]  data_out_q, data_out_d;
    logic        oe_q, oe_d;

    logic       commit, busy, rd_active;
    logic       ram_we;
    logic [6:0] ram_idx;
    logic [7:0] ram_wdata, ram_rdata;
    logic [7:0] cg_rdata;
    logic       rd_valid;
    logic [6:0] rd_idx;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            e_sync_q     <= '0;
            rs_sync_q    <= '0;
            rw_sync_q    <= '0;
            data_sync1_q <= '0;
            data_sync2_q <= '0;
            e_prev_q     <= 1'b0;
            rs_prev_q    <= 1'b0;
            rw_prev_q    <= 1'b0;
            data_prev_q  <= '0;
        end else begin
            e_sync_q     <= {e_sync_q[0], LCD_E};
            rs_sync_q    <= {rs_sync_q[0], LCD_RS};
            rw_sync_q    <= {rw_sync_q[0], LCD_RW};
            data_sync1_q <= LCD_DATA_IN;
            data_sync2_q <= data_sync1_q;
            e_prev_q     <= e_sync_q[1];
            rs_prev_q    <= rs_sync_q[1];
            rw_prev_q    <= rw_sync_q[1];
            data_prev_q  <= data_sync2_q;
        end
    end

    // Falling edge of synced E; bus fields come from the last cycle E was high
    assign commit    = e_prev_q & ~e_sync_q[1];
    assign busy      = (state_q != StIdle);
    assign rd_active = e_sync_q[1] & rw_sync_q[1];

`ifdef LCD_RESP_CGRAM_EN
    logic       cg_we;
    logic [7:0] cgram_mem [64];

    always_ff @(posedge CLK) begin
        if (cg_we) begin
            cgram_mem[ac_q[5:0]] <= data_prev_q;
        end
    end

    assign cg_rdata = cgram_mem[ac_q[5:0]];
`else
    assign cg_rdata = 8'h00;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        fill_d     = fill_q;
        ac_d       = ac_q;
        id_d       = id_q;
        space_d    = space_q;
        disp_d     = disp_q;
        err_d      = err_q;
        ram_we     = 1'b0;
        ram_idx    = addr_to_index(ac_q);
        ram_wdata  = data_prev_q;
`ifdef LCD_RESP_CGRAM_EN
        cg_we      = 1'b0;
`endif
        oe_d       = rd_active;
        data_out_d = data_out_q;

        if (rd_active) begin
            if (rs_sync_q[1]) begin
                data_out_d = (space_q == SpaceCgram) ? cg_rdata : ram_rdata;
            end else begin
                data_out_d = {busy, ac_q};
            end
        end

        if (commit && rw_prev_q && rs_prev_q) begin
            ac_d = ac_step(ac_q, id_q, space_q == SpaceCgram);
        end

        if (commit && !rw_prev_q && busy) begin
            err_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (commit && !rw_prev_q) begin
                    state_d = StBusyWait;
                    cnt_d   = ShortLoad;
                    if (rs_prev_q) begin
                        if (space_q == SpaceDdram) begin
                            ram_we = 1'b1;
                            ac_d   = ac_step(ac_q, id_q, 1'b0);
                        end else begin
`ifdef LCD_RESP_CGRAM_EN
                            cg_we = 1'b1;
                            ac_d  = ac_step(ac_q, id_q, 1'b1);
`else
                            err_d = 1'b1;
`endif
                        end
                    end else begin
                        unique casez (data_prev_q)
                            8'b1???????: begin
                                space_d = SpaceDdram;
                                if (ddram_addr_valid(data_prev_q[6:0])) begin
                                    ac_d = data_prev_q[6:0];
                                end else begin
                                    ac_d  = 7'h00;
                                    err_d = 1'b1;
                                end
                            end
                            8'b01??????: begin
                                space_d = SpaceCgram;
                                ac_d    = {1'b0, data_prev_q[5:0]};
                            end
                            8'b001?????: begin
                                if (!data_prev_q[FUNC_DL_BIT]) begin
                                    err_d = 1'b1;
                                end
                            end
                            8'b0001????: begin
                                if (!data_prev_q[SHIFT_SC_BIT]) begin
                                    ac_d = ac_step(ac_q, data_prev_q[SHIFT_RL_BIT],
                                                   space_q == SpaceCgram);
                                end
                            end
                            8'b00001???: disp_d = data_prev_q[2:0];
                            8'b000001??: begin
                                id_d = data_prev_q[ENTRY_ID_BIT];
                                if (data_prev_q[ENTRY_S_BIT]) begin
                                    err_d = 1'b1;
                                end
                            end
                            8'b0000001?: begin
                                ac_d    = 7'h00;
                                space_d = SpaceDdram;
                                cnt_d   = LongLoad;
                            end
                            8'b00000001: begin
                                state_d = StClear;
                                fill_d  = 7'h00;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            StClear: begin
                ram_we    = 1'b1;
                ram_idx   = fill_q;
                ram_wdata = BLANK_CHAR;
                if (fill_q == FillLast) begin
                    state_d = StBusyWait;
                    cnt_d   = LongLoad;
                    ac_d    = 7'h00;
                    id_d    = 1'b1;
                    space_d = SpaceDdram;
                end else begin
                    fill_d = fill_q + 7'd1;
                end
            end
            StBusyWait: begin
                if (cnt_q == 16'd0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            fill_q     <= '0;
            ac_q       <= '0;
            id_q       <= 1'b1;
            space_q    <= SpaceDdram;
            disp_q     <= '0;
            err_q      <= 1'b0;
            data_out_q <= '0;
            oe_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            fill_q     <= fill_d;
            ac_q       <= ac_d;
            id_q       <= id_d;
            space_q    <= space_d;
            disp_q     <= disp_d;
            err_q      <= err_d;
            data_out_q <= data_out_d;
            oe_q       <= oe_d;
        end
    end

    assign rd_valid = ddram_addr_valid(RD_ADDR);
    assign rd_idx   = addr_to_index(RD_ADDR);

    lcd_ddram u_ddram (
        .clk_i       (CLK),
        .rst_i       (RESET),
        .bus_we_i    (ram_we),
        .bus_idx_i   (ram_idx),
        .bus_wdata_i (ram_wdata),
        .bus_rdata_o (ram_rdata),
        .rd_valid_i  (rd_valid),
        .rd_idx_i    (rd_idx),
        .rd_char_o   (RD_CHAR)
    );

    assign LCD_DATA_OUT = data_out_q;
    assign LCD_DATA_OE  = oe_q;
    assign DISP_CTRL    = disp_q;
    assign BUSY         = busy;
    assign ERR          = err_q;

endmodule
